layer2_sequencer: RTL and testbench
===================================

# layer2_sequencer

Channel sequencer for the layer-2 max-pooling stage. On a layer start it launches the pooling datapath once per output channel, counts that channel's pooled results, and writes each result into the layer-2 feature buffer at a linear address. It then advances to the next channel and pulses done after the last one. It sits between the network-level controller and the layer-2 datapath, driving its `start_flag` and consuming its `data_out` / `out_valid`.

## Interface

Parameters:
- `NUM_CH`, 6: number of output channels sequenced per layer run.
- `OUT_PER_CH`, 144: pooled results expected per channel (12x12).
- `TIMEOUT_CYC`, 4096: maximum cycles between a launch or accepted result and the next result. Used only when the timeout feature is compiled in.
- Derived widths:
  - `CH_W` = max(1, clog2(`NUM_CH`)).
  - `CNT_W` = clog2(`OUT_PER_CH`+1).
  - `ADDR_W` = clog2(`NUM_CH`*`OUT_PER_CH`).

Ports:
- `sys_clk`  in  1  clock; all logic on the rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `layer_start`  in  1  request to run the layer; sampled only in IDLE.
- `busy`  out  1  high from the cycle after start acceptance until DONE exits.
- `layer_done`  out  1  one-cycle pulse when all channels are complete.
- `ch_idx`  out  `CH_W`  channel currently being processed.
- `pool_start`  out  1  one-cycle launch pulse to the datapath `start_flag`.
- `pool_valid`  in  1  result strobe from the datapath.
- `pool_data`  in  33  result data from the datapath.
- `wr_en`  out  1  feature-buffer write strobe.
- `wr_addr`  out  `ADDR_W`  write address, equal to `ch_idx`*`OUT_PER_CH` + result count.
- `wr_data`  out  33  registered copy of `pool_data`.
- `err_timeout`  out  1  sticky error flag; held at 0 when the feature is compiled out.

## Operation

States: IDLE, LAUNCH, COLLECT, NEXT, DONE, ERR.

- **IDLE**: when `layer_start`=1, go to LAUNCH, clear `ch_idx`, the result counter and the base address.
- **LAUNCH**: assert `pool_start` for exactly one cycle, clear the result counter and the timeout counter, go to COLLECT.
- **COLLECT**: each cycle with `pool_valid`=1:
  - register `wr_en`=1, `wr_data`=`pool_data`, `wr_addr`=base+count;
  - increment the count.
  - When the count reaches `OUT_PER_CH`, go to NEXT in the same cycle as that final write.
- **NEXT**:
  - If `ch_idx`=`NUM_CH`-1, go to DONE.
  - Otherwise increment `ch_idx`, add `OUT_PER_CH` to the base and go to LAUNCH.
- **DONE**: `layer_done`=1 for one cycle, then IDLE.
- **ERR**: reached only through timeout. `busy`=0 and `err_timeout`=1. Stays in ERR until `sys_rst`.

Boundary rules:
- `layer_start` outside IDLE is ignored; it is never queued.
- `pool_valid` outside COLLECT is dropped: no write, no count change.
- Address arithmetic is unsigned. The base address is held in a register, so no multiplier is needed. The maximum address is `NUM_CH`*`OUT_PER_CH`-1 (863 by default) and never wraps.
- `pool_data` is passed through unmodified at 33 bits.
- `sys_rst` asserted in any state (including mid-channel) returns the block to IDLE on the next edge. There is no partial-layer resume.

## Timing

- Reset values: `busy`=0, `layer_done`=0, `ch_idx`=0, `pool_start`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `err_timeout`=0.
- Start is accepted at edge N (`layer_start` high in IDLE). `busy` and `pool_start` are both high in cycle N+1.
- Write latency: `pool_valid` high at edge K gives `wr_en` high during cycle K+1. `wr_en` is a single-cycle strobe per result, and back-to-back `pool_valid` yields back-to-back writes.
- Channel gap: the last write of channel c is followed by NEXT (1 cycle), then LAUNCH. The next `pool_start` therefore follows the final `pool_valid` by 2 cycles.
- `layer_done` is high 2 cycles after the final `pool_valid` of the last channel. `busy` drops in the cycle after `layer_done`.

## Configuration

- Macro `LAYER2_SEQ_TIMEOUT_EN`.
- **Defined**: a counter in COLLECT resets on entry and on each `pool_valid`, and increments otherwise. When it reaches `TIMEOUT_CYC`, the FSM enters ERR and `err_timeout` is set.
- **Undefined**: the counter and ERR state are not built, COLLECT waits indefinitely, and `err_timeout` is tied to 0.

## Test plan

- **Reset:** assert `sys_rst` for 3 cycles -> all outputs 0, state IDLE; `layer_start` pulsed while `sys_rst`=1 is ignored.
- **Nominal run** (defaults):
  - Stimulus: start, datapath returns 144 valids per launch.
  - Required: 6 `pool_start` pulses and 864 writes at addresses 0..863 in order; `wr_data` matches input; one `layer_done`; `ch_idx` steps 0..5.
- **Spacing:** valids every 3rd cycle with channel boundary checks -> next `pool_start` exactly 2 cycles after the 144th valid; no write in the gap.
- **Spurious inputs:** `pool_valid` during IDLE/LAUNCH/NEXT and `layer_start` mid-run -> no write, no count change, run completes normally.
- **Mid-run reset:** `sys_rst` after 70 results in channel 2 -> IDLE next edge. A fresh start then writes from address 0 with `ch_idx`=0.
- **Timeout** (macro defined, `TIMEOUT_CYC`=16): stall after 10 results -> `err_timeout`=1 and `busy`=0 after 16 idle cycles, no `layer_done`; recovers only after `sys_rst`.

Source files
------------

// File: rtl/layer2_sequencer.sv
// ----------------------------------------------------------------------------
// layer2_sequencer
//
// Channel sequencer for the layer-2 max-pooling stage. A layer start launches
// the pooling datapath once per output channel, counts that channel's pooled
// results and writes each one into the layer-2 feature buffer at the linear
// address ch_idx*OUT_PER_CH + result_count. After the last channel a single
// layer_done pulse is issued and the block returns to idle.
//
// Optional feature:
//   LAYER2_SEQ_TIMEOUT_EN  - when defined, a watchdog in COLLECT moves the
//                            FSM into a sticky ERR state if no result arrives
//                            within TIMEOUT_CYC cycles. When undefined the
//                            watchdog and ERR state are not built and
//                            err_timeout is tied low.
//
// Ports:
//   sys_clk      in   1       clock, rising edge
//   sys_rst      in   1       synchronous active-high reset
//   layer_start  in   1       run request, only honoured in IDLE
//   busy         out  1       layer run in progress
//   layer_done   out  1       one-cycle pulse after the last channel
//   ch_idx       out  CH_W    channel currently being processed
//   pool_start   out  1       one-cycle launch pulse to the pooling datapath
//   pool_valid   in   1       result strobe from the datapath
//   pool_data    in   33      result data from the datapath
//   wr_en        out  1       feature-buffer write strobe
//   wr_addr      out  ADDR_W  feature-buffer write address
//   wr_data      out  33      registered copy of pool_data
//   err_timeout  out  1       sticky watchdog error flag
// ----------------------------------------------------------------------------
module layer2_sequencer #(
    parameter int  NUM_CH      = 6,
    parameter int  OUT_PER_CH  = 144,
    parameter int  TIMEOUT_CYC = 4096,
    localparam int CH_W        = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W       = $clog2(OUT_PER_CH + 1),
    localparam int ADDR_W      = $clog2(NUM_CH * OUT_PER_CH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              layer_start,
    output logic              busy,
    output logic              layer_done,
    output logic [CH_W-1:0]   ch_idx,
    output logic              pool_start,
    input  logic              pool_valid,
    input  logic [32:0]       pool_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [32:0]       wr_data,
    output logic              err_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_COLLECT = 3'd2,
        ST_NEXT    = 3'd3,
        ST_DONE    = 3'd4
`ifdef LAYER2_SEQ_TIMEOUT_EN
        ,
        ST_ERR     = 3'd5
`endif
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(OUT_PER_CH);
    localparam logic [ADDR_W-1:0] BASE_STEP = ADDR_W'(OUT_PER_CH);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);

    state_t            r_state;
    logic              r_busy;
    logic              r_layer_done;
    logic              r_pool_start;
    logic              r_wr_en;
    logic [CH_W-1:0]   r_ch_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [32:0]       r_wr_data;

    logic [CNT_W-1:0]  w_cnt_inc;
    logic [ADDR_W-1:0] w_addr;

    // The base register advances by OUT_PER_CH per channel, so the write
    // address is a single add instead of ch_idx*OUT_PER_CH.
    assign w_cnt_inc = r_cnt + CNT_W'(1'b1);
    assign w_addr    = r_base + ADDR_W'(r_cnt);

`ifdef LAYER2_SEQ_TIMEOUT_EN
    localparam int               TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC);

    logic             r_err_timeout;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [TMO_W-1:0] w_tmo_inc;

    assign w_tmo_inc   = r_tmo_cnt + TMO_W'(1'b1);
    assign err_timeout = r_err_timeout;
`else
    logic w_unused_tmo;

    assign w_unused_tmo = (TIMEOUT_CYC > 32'sd0);
    assign err_timeout  = 1'b0;
`endif

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_layer_done <= 1'b0;
            r_pool_start <= 1'b0;
            r_wr_en      <= 1'b0;
            r_ch_idx     <= {CH_W{1'b0}};
            r_cnt        <= {CNT_W{1'b0}};
            r_base       <= {ADDR_W{1'b0}};
            r_wr_addr    <= {ADDR_W{1'b0}};
            r_wr_data    <= 33'd0;
`ifdef LAYER2_SEQ_TIMEOUT_EN
            r_tmo_cnt     <= {TMO_W{1'b0}};
            r_err_timeout <= 1'b0;
`endif
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            r_pool_start <= 1'b0;
            r_layer_done <= 1'b0;
            r_wr_en      <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (layer_start) begin
                        r_state      <= ST_LAUNCH;
                        r_busy       <= 1'b1;
                        r_pool_start <= 1'b1;
                        r_ch_idx     <= {CH_W{1'b0}};
                        r_cnt        <= {CNT_W{1'b0}};
                        r_base       <= {ADDR_W{1'b0}};
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_LAUNCH: begin
                    // pool_start is high for this one cycle; results are
                    // accepted from the next edge onwards.
                    r_cnt   <= {CNT_W{1'b0}};
`ifdef LAYER2_SEQ_TIMEOUT_EN
                    r_tmo_cnt <= {TMO_W{1'b0}};
`endif
                    r_state <= ST_COLLECT;
                end

                ST_COLLECT: begin
                    if (pool_valid) begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= pool_data;
                        r_wr_addr <= w_addr;
                        r_cnt     <= w_cnt_inc;
`ifdef LAYER2_SEQ_TIMEOUT_EN
                        r_tmo_cnt <= {TMO_W{1'b0}};
`endif
                        // Leave on the same edge as the final write.
                        if (w_cnt_inc == CNT_LAST) begin
                            r_state <= ST_NEXT;
                        end else begin
                            r_state <= ST_COLLECT;
                        end
                    end
`ifdef LAYER2_SEQ_TIMEOUT_EN
                    else if (w_tmo_inc == TMO_LIMIT) begin
                        r_state       <= ST_ERR;
                        r_busy        <= 1'b0;
                        r_err_timeout <= 1'b1;
                        r_tmo_cnt     <= w_tmo_inc;
                    end else begin
                        r_tmo_cnt <= w_tmo_inc;
                        r_state   <= ST_COLLECT;
                    end
`else
                    else begin
                        r_state <= ST_COLLECT;
                    end
`endif
                end

                ST_NEXT: begin
                    if (r_ch_idx == CH_LAST) begin
                        r_state      <= ST_DONE;
                        r_layer_done <= 1'b1;
                    end else begin
                        r_state      <= ST_LAUNCH;
                        r_pool_start <= 1'b1;
                        r_ch_idx     <= r_ch_idx + CH_W'(1'b1);
                        r_base       <= r_base + BASE_STEP;
                    end
                end

                ST_DONE: begin
                    // busy covers the layer_done cycle and drops afterwards.
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

`ifdef LAYER2_SEQ_TIMEOUT_EN
                ST_ERR: begin
                    // Sticky until sys_rst; every input is ignored here.
                    r_busy        <= 1'b0;
                    r_err_timeout <= 1'b1;
                    r_state       <= ST_ERR;
                end
`endif

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign layer_done = r_layer_done;
    assign ch_idx     = r_ch_idx;
    assign pool_start = r_pool_start;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;

endmodule

// File: tb/tb_layer2_sequencer.sv
// ----------------------------------------------------------------------------
// tb_layer2_sequencer
//
// Self-checking bench for layer2_sequencer. The bench plays the pooling
// datapath with randomized result timing and data. A cycle-indexed
// scoreboard is filled from the timing rules of the block: a result accepted
// at an edge is written in the following cycle at ch*OUT_PER_CH+n, the next
// launch follows a channel's final result by two cycles, and layer_done /
// busy follow the last channel's final result by two / three cycles.
// ----------------------------------------------------------------------------
module tb_layer2_sequencer;

    localparam int NUM_CH     = 6;
    localparam int OUT_PER_CH = 144;
`ifdef LAYER2_SEQ_TIMEOUT_EN
    localparam int TMO        = 16;
    localparam int STALL_CYC  = TMO + 8;
`else
    localparam int TMO        = 4096;
    localparam int STALL_CYC  = 40;
`endif
    localparam int CH_W       = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;
    localparam int ADDR_W     = $clog2(NUM_CH * OUT_PER_CH);
    localparam int MAXC       = 8192;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              layer_start;
    logic              busy;
    logic              layer_done;
    logic [CH_W-1:0]   ch_idx;
    logic              pool_start;
    logic              pool_valid;
    logic [32:0]       pool_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [32:0]       wr_data;
    logic              err_timeout;

    always #5 sys_clk = ~sys_clk;

    layer2_sequencer #(
        .NUM_CH      (NUM_CH),
        .OUT_PER_CH  (OUT_PER_CH),
        .TIMEOUT_CYC (TMO)
    ) u_dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .layer_start (layer_start),
        .busy        (busy),
        .layer_done  (layer_done),
        .ch_idx      (ch_idx),
        .pool_start  (pool_start),
        .pool_valid  (pool_valid),
        .pool_data   (pool_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .err_timeout (err_timeout)
    );

    int tests_run;
    int tests_failed;

    // Scoreboard, indexed by cycle number within the current scenario.
    int          cyc;
    bit          exp_wr   [MAXC];
    int          exp_addr [MAXC];
    logic [32:0] exp_data [MAXC];
    bit          exp_ps   [MAXC];
    bit          exp_done [MAXC];
    int          exp_ch   [MAXC];
    int          busy_from, busy_to;
    int          err_from, err_to;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_model();
        cyc       = 0;
        busy_from = MAXC;
        busy_to   = MAXC;
        err_from  = MAXC;
        err_to    = MAXC;
        for (int i = 0; i < MAXC; i++) begin
            exp_wr[i]   = 1'b0;
            exp_addr[i] = 0;
            exp_data[i] = 33'd0;
            exp_ps[i]   = 1'b0;
            exp_done[i] = 1'b0;
            exp_ch[i]   = 0;
        end
    endtask

    // Advance one clock and compare every output away from the active edge.
    task automatic step();
        @(posedge sys_clk);
        @(negedge sys_clk);
        cyc++;
        if (cyc >= MAXC - 4) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 4);
            $fatal(1, "scenario exceeded its cycle budget");
        end
        chk_eq("wr_en", 64'(wr_en), 64'(exp_wr[cyc]));
        if (exp_wr[cyc]) begin
            chk_eq("wr_addr", 64'(wr_addr), 64'(exp_addr[cyc]));
            chk_eq("wr_data", 64'(wr_data), 64'(exp_data[cyc]));
            chk_eq("ch_idx_wr", 64'(ch_idx), 64'(exp_ch[cyc]));
        end
        chk_eq("pool_start", 64'(pool_start), 64'(exp_ps[cyc]));
        if (exp_ps[cyc]) begin
            chk_eq("ch_idx_launch", 64'(ch_idx), 64'(exp_ch[cyc]));
        end
        chk_eq("layer_done", 64'(layer_done), 64'(exp_done[cyc]));
        chk_eq("busy", 64'(busy), 64'((cyc >= busy_from) && (cyc < busy_to)));
        chk_eq("err_timeout", 64'(err_timeout), 64'((cyc >= err_from) && (cyc < err_to)));
    endtask

    task automatic check_cleared(input string tag);
        chk_eq({tag, "_ch_idx"}, 64'(ch_idx), 64'd0);
        chk_eq({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        chk_eq({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    endtask

    task automatic reset_seq();
        clear_model();
        // layer_start and pool_valid are held high during reset and must be ignored.
        sys_rst     = 1'b1;
        layer_start = 1'b1;
        pool_valid  = 1'b1;
        pool_data   = 33'h1_2345_6789;
        repeat (3) step();
        check_cleared("reset");
        sys_rst     = 1'b0;
        layer_start = 1'b0;
        pool_valid  = 1'b0;
        repeat (2) step();
    endtask

    task automatic abort_reset();
        sys_rst     = 1'b1;
        layer_start = 1'b0;
        pool_valid  = 1'b0;
        if (busy_to > cyc + 1) busy_to = cyc + 1;
        err_to = cyc + 1;
        step();
        check_cleared("abort");
        sys_rst = 1'b0;
        step();
    endtask

    // gap: 0 = random spacing, k>0 = a result every k-th cycle of the window.
    // spur: inject spurious pool_valid / layer_start outside their windows.
    // mode: 0 = full run, 1 = reset after ab_n results of channel ab_ch,
    //       2 = stall after ab_n results of channel ab_ch, then reset.
    task automatic run_layer(input int gap, input bit spur, input int mode,
                             input int ab_ch, input int ab_n);
        int          ch;
        int          n;
        int          open_from;
        int          tl;
        bit          fin;
        bit          aborted;
        bit          v;
        bit          in_win;
        logic [63:0] rnd;

        clear_model();
        ch      = 0;
        n       = 0;
        fin     = 1'b0;
        aborted = 1'b0;
        rnd     = {$urandom(), $urandom()};

        layer_start = 1'b1;
        pool_valid  = spur;
        pool_data   = rnd[32:0];
        exp_ps[1]   = 1'b1;
        exp_ch[1]   = 0;
        busy_from   = 1;
        open_from   = 2;

        while (!fin) begin
            step();
            if ((mode != 0) && (ch == ab_ch) && (n == ab_n)) begin
                tl          = cyc - 1;
                layer_start = 1'b0;
                pool_valid  = 1'b0;
                if (mode == 2) begin
`ifdef LAYER2_SEQ_TIMEOUT_EN
                    err_from = tl + 1 + TMO;
                    busy_to  = err_from;
`endif
                    for (int k = 0; k < STALL_CYC; k++) begin
                        step();
                        layer_start = ($urandom_range(0, 3) == 0);
                        pool_valid  = 1'b0;
                    end
                end
                abort_reset();
                fin     = 1'b1;
                aborted = 1'b1;
            end else begin
                layer_start = spur && ($urandom_range(0, 15) == 0);
                in_win      = (cyc >= open_from);
                if (in_win) begin
                    if (gap == 0) v = ($urandom_range(0, 3) != 0);
                    else          v = (((cyc - open_from) % gap) == 0);
                end else begin
                    v = spur && ($urandom_range(0, 1) == 1);
                end
                rnd        = {$urandom(), $urandom()};
                pool_valid = v;
                pool_data  = rnd[32:0];
                if (v && in_win) begin
                    exp_wr[cyc + 1]   = 1'b1;
                    exp_addr[cyc + 1] = ch * OUT_PER_CH + n;
                    exp_data[cyc + 1] = rnd[32:0];
                    exp_ch[cyc + 1]   = ch;
                    n++;
                    if (n == OUT_PER_CH) begin
                        if (ch == NUM_CH - 1) begin
                            exp_done[cyc + 2] = 1'b1;
                            busy_to           = cyc + 3;
                            fin               = 1'b1;
                        end else begin
                            exp_ps[cyc + 2] = 1'b1;
                            exp_ch[cyc + 2] = ch + 1;
                            ch++;
                            n         = 0;
                            open_from = cyc + 3;
                        end
                    end
                end
            end
        end

        if (!aborted) begin
            for (int k = 0; k < 4; k++) begin
                step();
                rnd         = {$urandom(), $urandom()};
                layer_start = 1'b0;
                pool_valid  = spur && ($urandom_range(0, 1) == 1);
                pool_data   = rnd[32:0];
            end
        end
        layer_start = 1'b0;
        pool_valid  = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        sys_rst      = 1'b1;
        layer_start  = 1'b0;
        pool_valid   = 1'b0;
        pool_data    = 33'd0;

        reset_seq();
        run_layer(0, 1'b0, 0, 0, 0);    // nominal, random result spacing
        run_layer(3, 1'b0, 0, 0, 0);    // one result every third cycle
        run_layer(0, 1'b1, 0, 0, 0);    // spurious valids and starts
        run_layer(0, 1'b1, 1, 2, 70);   // reset after 70 results of channel 2
        run_layer(1, 1'b0, 0, 0, 0);    // fresh run, back-to-back results
        run_layer(0, 1'b0, 2, 0, 10);   // stall after 10 results
        run_layer(0, 1'b0, 0, 0, 0);    // normal run after recovery

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
